// File: rtl/pw_conv_par_oc.sv
// pw_conv_par_oc: pointwise (1x1) convolution for one pixel. PAR_OC output
// channels are accumulated in parallel, requantised per lane with optional
// ReLU6, then serialised as int8 results on one output stream.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, cfg_in_ch         begin a pixel with cfg_in_ch (>=1) input channels
//   in_valid/in_ready/in_data  activation stream, one beat per input channel
//   w_flat, acc_bias_flat    per-lane weights and initial accumulators
//   mul_flat, rq_bias_flat, shift_flat, relu6_max, relu6_en  requant controls
//   out_valid/out_ready/out_data/out_lane/out_last  serialised results
//   busy                     high whenever the engine is not idle
//
// Build option: define PW_PAR_OC_ACC_SAT_EN to saturate the accumulators
// instead of letting them wrap.
module pw_conv_par_oc #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ACC_W     = 32,
  parameter int unsigned PAR_OC    = 4,
  parameter int unsigned MAX_IN_CH = 1024,
  parameter int unsigned MUL_W     = 16,
  parameter int unsigned BIAS_W    = 32,
  parameter int unsigned SHIFT_W   = 6,
  localparam int unsigned CH_W     = $clog2(MAX_IN_CH + 1),
  localparam int unsigned LANE_W   = (PAR_OC > 1) ? $clog2(PAR_OC) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [CH_W-1:0]             cfg_in_ch,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [DATA_W-1:0]    in_data,
  input  logic [DATA_W*PAR_OC-1:0]    w_flat,
  input  logic [ACC_W*PAR_OC-1:0]     acc_bias_flat,
  input  logic [MUL_W*PAR_OC-1:0]     mul_flat,
  input  logic [BIAS_W*PAR_OC-1:0]    rq_bias_flat,
  input  logic [SHIFT_W*PAR_OC-1:0]   shift_flat,
  input  logic signed [DATA_W-1:0]    relu6_max,
  input  logic                        relu6_en,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [DATA_W-1:0]    out_data,
  output logic [LANE_W-1:0]           out_lane,
  output logic                        out_last,
  output logic                        busy
);

  localparam int unsigned PROD_W = ACC_W + MUL_W;
  // Wide enough that the rounding constant for any shift cannot overflow.
  localparam int unsigned RQ_W   = PROD_W + (2 ** SHIFT_W);
  localparam logic signed [RQ_W-1:0] Q_MAX = RQ_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [RQ_W-1:0] Q_MIN = ~Q_MAX;

  typedef enum logic [1:0] {IDLE, ACC, RQ, OUT} state_t;

  state_t                    state;
  logic [CH_W-1:0]           in_ch;
  logic [CH_W-1:0]           cnt;
  logic [LANE_W-1:0]         lane;
  logic signed [ACC_W-1:0]   acc     [PAR_OC];
  logic signed [DATA_W-1:0]  q       [PAR_OC];
  logic signed [ACC_W-1:0]   acc_nxt [PAR_OC];
  logic signed [DATA_W-1:0]  q_nxt   [PAR_OC];

  // One accumulation step: wrap by default, saturate when the option is built in.
  function automatic logic signed [ACC_W-1:0] acc_step(
    input logic signed [ACC_W-1:0]    base,
    input logic signed [2*DATA_W-1:0] prod
  );
`ifdef PW_PAR_OC_ACC_SAT_EN
    logic signed [ACC_W:0] s;
    logic signed [ACC_W-1:0] r;
    s = (ACC_W + 1)'(base) + (ACC_W + 1)'(prod);
    if (s[ACC_W] != s[ACC_W-1])
      r = s[ACC_W] ? {1'b1, {(ACC_W - 1){1'b0}}} : {1'b0, {(ACC_W - 1){1'b1}}};
    else
      r = s[ACC_W-1:0];
    return r;
`else
    return base + ACC_W'(prod);
`endif
  endfunction

  // Multiply, round half up, shift, add bias, saturate to int8, optional ReLU6.
  function automatic logic signed [DATA_W-1:0] requant(
    input logic signed [ACC_W-1:0]  a,
    input logic signed [MUL_W-1:0]  m,
    input logic [SHIFT_W-1:0]       sh,
    input logic signed [BIAS_W-1:0] b,
    input logic                     en,
    input logic signed [DATA_W-1:0] mx
  );
    logic signed [PROD_W-1:0] p;
    logic signed [RQ_W-1:0]   rnd;
    logic signed [RQ_W-1:0]   v;
    logic signed [DATA_W-1:0] r;
    p   = a * m;
    rnd = '0;
    if (sh != '0) rnd = RQ_W'(1) <<< (sh - SHIFT_W'(1));
    v = (RQ_W'(p) + rnd) >>> sh;
    v = v + RQ_W'(b);
    if (v > Q_MAX)      r = {1'b0, {(DATA_W - 1){1'b1}}};
    else if (v < Q_MIN) r = {1'b1, {(DATA_W - 1){1'b0}}};
    else                r = DATA_W'(v);
    if (en) begin
      if (r[DATA_W-1])  r = '0;
      else if (r > mx)  r = mx;
    end
    return r;
  endfunction

  // Per-lane datapath: next accumulator and requantised result.
  always_comb begin
    for (int k = 0; k < PAR_OC; k++) begin
      acc_nxt[k] = acc_step(
        (cnt == '0) ? $signed(acc_bias_flat[k*ACC_W +: ACC_W]) : acc[k],
        in_data * $signed(w_flat[k*DATA_W +: DATA_W]));
      q_nxt[k] = requant(acc[k],
                         $signed(mul_flat[k*MUL_W +: MUL_W]),
                         shift_flat[k*SHIFT_W +: SHIFT_W],
                         $signed(rq_bias_flat[k*BIAS_W +: BIAS_W]),
                         relu6_en, relu6_max);
    end
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      in_ch <= '0;
      cnt   <= '0;
      lane  <= '0;
      for (int k = 0; k < PAR_OC; k++) begin
        acc[k] <= '0;
        q[k]   <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (start && (cfg_in_ch != '0)) begin
            in_ch <= cfg_in_ch;
            cnt   <= '0;
            state <= ACC;
          end
        end
        ACC: begin
          if (in_valid) begin
            for (int k = 0; k < PAR_OC; k++) acc[k] <= acc_nxt[k];
            if (cnt == in_ch - CH_W'(1)) begin
              cnt   <= '0;
              state <= RQ;
            end else begin
              cnt <= cnt + CH_W'(1);
            end
          end
        end
        RQ: begin
          for (int k = 0; k < PAR_OC; k++) q[k] <= q_nxt[k];
          lane  <= '0;
          state <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            if (lane == LANE_W'(PAR_OC - 1)) begin
              lane  <= '0;
              state <= IDLE;
            end else begin
              lane <= lane + LANE_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode directly from registered state.
  assign in_ready  = (state == ACC);
  assign out_valid = (state == OUT);
  assign busy      = (state != IDLE);
  assign out_data  = q[lane];
  assign out_lane  = lane;
  assign out_last  = out_valid && (lane == LANE_W'(PAR_OC - 1));

endmodule

// File: tb/tb_pw_conv_par_oc.sv
// Directed, table-driven bench for pw_conv_par_oc (default parameters).
module tb_pw_conv_par_oc;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned ACC_W     = 32;
  localparam int unsigned PAR_OC    = 4;
  localparam int unsigned MAX_IN_CH = 1024;
  localparam int unsigned MUL_W     = 16;
  localparam int unsigned BIAS_W    = 32;
  localparam int unsigned SHIFT_W   = 6;
  localparam int unsigned CH_W      = 11;
  localparam int unsigned LANE_W    = 2;

`ifdef PW_PAR_OC_ACC_SAT_EN
  localparam int OVF_EXP = 127;
`else
  localparam int OVF_EXP = -128;
`endif

  typedef struct {
    int                          in_ch;
    logic [2:0][DATA_W-1:0]      din;
    logic [PAR_OC-1:0][DATA_W-1:0] w;
    int                          bias;
    int                          mul;
    int                          sh;
    int                          rqb;
    int                          ren;
    int                          rmax;
    int                          exp_q [PAR_OC];
  } vec_t;

  logic                       clk;
  logic                       rst;
  logic                       start;
  logic [CH_W-1:0]            cfg_in_ch;
  logic                       in_valid;
  logic                       in_ready;
  logic [DATA_W-1:0]          in_data;
  logic [DATA_W*PAR_OC-1:0]   w_flat;
  logic [ACC_W*PAR_OC-1:0]    acc_bias_flat;
  logic [MUL_W*PAR_OC-1:0]    mul_flat;
  logic [BIAS_W*PAR_OC-1:0]   rq_bias_flat;
  logic [SHIFT_W*PAR_OC-1:0]  shift_flat;
  logic [DATA_W-1:0]          relu6_max;
  logic                       relu6_en;
  logic                       out_valid;
  logic                       out_ready;
  logic [DATA_W-1:0]          out_data;
  logic [LANE_W-1:0]          out_lane;
  logic                       out_last;
  logic                       busy;

  int errors = 0;
  int checks = 0;

  pw_conv_par_oc #(
    .DATA_W(DATA_W), .ACC_W(ACC_W), .PAR_OC(PAR_OC), .MAX_IN_CH(MAX_IN_CH),
    .MUL_W(MUL_W), .BIAS_W(BIAS_W), .SHIFT_W(SHIFT_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_in_ch(cfg_in_ch),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .w_flat(w_flat), .acc_bias_flat(acc_bias_flat), .mul_flat(mul_flat),
    .rq_bias_flat(rq_bias_flat), .shift_flat(shift_flat),
    .relu6_max(relu6_max), .relu6_en(relu6_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_lane(out_lane), .out_last(out_last), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int in_ch, input int d0, input int d1, input int d2,
                              input int w0, input int w1, input int w2, input int w3,
                              input int bias, input int mul, input int sh, input int rqb,
                              input int ren, input int rmax,
                              input int e0, input int e1, input int e2, input int e3);
    vec_t v;
    v.in_ch = in_ch;
    v.din[0] = DATA_W'(d0); v.din[1] = DATA_W'(d1); v.din[2] = DATA_W'(d2);
    v.w[0] = DATA_W'(w0); v.w[1] = DATA_W'(w1); v.w[2] = DATA_W'(w2); v.w[3] = DATA_W'(w3);
    v.bias = bias; v.mul = mul; v.sh = sh; v.rqb = rqb; v.ren = ren; v.rmax = rmax;
    v.exp_q[0] = e0; v.exp_q[1] = e1; v.exp_q[2] = e2; v.exp_q[3] = e3;
    return v;
  endfunction

  task automatic drive_cfg(input vec_t v);
    w_flat        = v.w;
    acc_bias_flat = {PAR_OC{ACC_W'(v.bias)}};
    mul_flat      = {PAR_OC{MUL_W'(v.mul)}};
    rq_bias_flat  = {PAR_OC{BIAS_W'(v.rqb)}};
    shift_flat    = {PAR_OC{SHIFT_W'(v.sh)}};
    relu6_en      = (v.ren != 0);
    relu6_max     = DATA_W'(v.rmax);
  endtask

  // One full pixel; optional 5-cycle stall on bp_lane with a stray start pulse.
  task automatic run_pixel(input vec_t v, input int bp_lane, input bit chk_lat, input string tag);
    int cyc;
    logic [DATA_W-1:0] held;
    drive_cfg(v);
    out_ready = 1'b1;
    @(negedge clk); start = 1'b1; cfg_in_ch = CH_W'(v.in_ch);
    @(negedge clk); start = 1'b0;
    for (int b = 0; b < v.in_ch; b++) begin
      in_valid = 1'b1;
      in_data  = v.din[b];
      cyc = 0;
      while (!in_ready && cyc < 20) begin @(negedge clk); cyc++; end
      if (!in_ready) chk({tag, " in_ready timeout"}, 0, 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 20) begin @(negedge clk); cyc++; end
    if (chk_lat) chk({tag, " latency"}, cyc, 2);
    for (int l = 0; l < PAR_OC; l++) begin
      cyc = 0;
      while (!out_valid && cyc < 20) begin @(negedge clk); cyc++; end
      chk($sformatf("%s lane%0d valid", tag, l), int'(out_valid), 1);
      chk($sformatf("%s lane%0d data", tag, l), int'($signed(out_data)), v.exp_q[l]);
      chk($sformatf("%s lane%0d idx", tag, l), int'(out_lane), l);
      chk($sformatf("%s lane%0d last", tag, l), int'(out_last), (l == PAR_OC - 1) ? 1 : 0);
      if (l == bp_lane) begin
        held = out_data;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
          start     = (i == 2);
          cfg_in_ch = CH_W'(3);
          @(negedge clk);
          chk($sformatf("%s stall%0d valid", tag, i), int'(out_valid), 1);
          chk($sformatf("%s stall%0d data", tag, i), int'(out_data), int'(held));
          chk($sformatf("%s stall%0d idx", tag, i), int'(out_lane), l);
        end
        start     = 1'b0;
        out_ready = 1'b1;
      end
      @(negedge clk);
    end
    chk({tag, " no extra output"}, int'(out_valid), 0);
    chk({tag, " idle after pixel"}, int'(busy), 0);
  endtask

  vec_t vecs [10];

  initial begin
    vecs[0] = mk(3, 1, 2, 3,   1, 2, 3, 4,   0, 1, 0, 0, 1, 127,   6, 12, 18, 24);
    vecs[1] = mk(1, 0, 0, 0,   1, 2, 3, 4,   5, 1, 1, 0, 0, 127,   3, 3, 3, 3);
    vecs[2] = mk(1, 0, 0, 0,   1, 2, 3, 4,  -5, 1, 1, 0, 0, 127,  -2, -2, -2, -2);
    vecs[3] = mk(1, 0, 0, 0,   1, 2, 3, 4,  -5, 1, 1, 0, 1, 127,   0, 0, 0, 0);
    vecs[4] = mk(1, 0, 0, 0,   1, 2, 3, 4, 1000, 1, 0, 0, 0, 127, 127, 127, 127, 127);
    vecs[5] = mk(1, 0, 0, 0,   1, 2, 3, 4, 1000, 1, 0, 0, 1, 6,     6, 6, 6, 6);
    vecs[6] = mk(1, 0, 0, 0,   1, 2, 3, 4, -1000, 1, 0, 0, 0, 127, -128, -128, -128, -128);
    vecs[7] = mk(1, 1, 0, 0,   1, 1, 1, 1, 2147483647, 1, 0, 0, 0, 127,
                 OVF_EXP, OVF_EXP, OVF_EXP, OVF_EXP);
    vecs[8] = mk(2, 10, -3, 0, 2, -4, 7, -1,  0, 3, 2, 1, 0, 127,  12, -20, 38, -4);
    vecs[9] = mk(2, 10, -3, 0, 2, -4, 7, -1,  0, 1, 0, 0, 1, 20,   14, 0, 20, 0);

    rst = 1'b1; start = 1'b0; cfg_in_ch = '0; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b1;
    drive_cfg(vecs[0]);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset in_ready", int'(in_ready), 0);
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset out_data", int'(out_data), 0);
    chk("reset out_lane", int'(out_lane), 0);
    chk("reset out_last", int'(out_last), 0);
    chk("reset busy", int'(busy), 0);

    // Zero-channel start is ignored.
    start = 1'b1; cfg_in_ch = '0;
    @(negedge clk); start = 1'b0;
    chk("zero-ch busy", int'(busy), 0);
    chk("zero-ch in_ready", int'(in_ready), 0);

    for (int i = 0; i < 10; i++)
      run_pixel(vecs[i], (i == 0) ? 1 : -1, (i == 0), $sformatf("vec%0d", i));

    // Reset after one of three beats discards the pixel.
    drive_cfg(vecs[0]);
    @(negedge clk); start = 1'b1; cfg_in_ch = CH_W'(3);
    @(negedge clk); start = 1'b0; in_valid = 1'b1; in_data = 8'd5;
    @(negedge clk); in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("midrst in_ready", int'(in_ready), 0);
    chk("midrst busy", int'(busy), 0);
    chk("midrst out_valid", int'(out_valid), 0);
    rst = 1'b0;
    run_pixel(vecs[0], -1, 1'b1, "post-rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pw_conv_par_oc.md
Name: pw_conv_par_oc

Overview:
Pointwise (1x1) convolution engine computing PAR_OC output channels in parallel for one pixel.
- Streams one activation per input channel and multiplies it against PAR_OC weights per beat, accumulating into per-lane accumulators.
- Applies per-lane requantisation and optional ReLU6, then serialises the PAR_OC int8 results on a single output stream.
- Next-generation pointwise stage of the depthwise-separable block: replaces the single-lane pointwise accumulator plus separate requant with a fused, lane-parallel, per-channel-quantised pipeline.

Parameters:
- DATA_W, 8, activation/weight/output width (signed).
- ACC_W, 32, accumulator width (signed).
- PAR_OC, 4, parallel output-channel lanes (>=1).
- MAX_IN_CH, 1024, maximum input channels per pixel.
- MUL_W, 16, requant multiplier width (signed).
- BIAS_W, 32, requant bias width (signed).
- SHIFT_W, 6, requant right-shift width (unsigned).
- Derived: CH_W = $clog2(MAX_IN_CH+1); LANE_W = max(1, $clog2(PAR_OC)).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin one pixel; sampled only in IDLE.
- cfg_in_ch  in  CH_W  input channels for this pixel; latched on start.
- in_valid  in  1  activation valid.
- in_ready  out  1  activation accepted.
- in_data  in  DATA_W  activation (signed).
- w_flat  in  DATA_W*PAR_OC  weights for current input channel; lane k = [k*DATA_W +: DATA_W].
- acc_bias_flat  in  ACC_W*PAR_OC  initial accumulator per lane; used on first beat.
- mul_flat  in  MUL_W*PAR_OC  per-lane multiplier.
- rq_bias_flat  in  BIAS_W*PAR_OC  per-lane post-shift bias.
- shift_flat  in  SHIFT_W*PAR_OC  per-lane right shift.
- relu6_max  in  DATA_W  ReLU6 upper clamp (shared).
- relu6_en  in  1  enable ReLU6 clamp.
- out_valid  out  1  result valid.
- out_ready  in  1  result accepted.
- out_data  out  DATA_W  quantised result (signed).
- out_lane  out  LANE_W  lane index of out_data.
- out_last  out  1  high on final lane (PAR_OC-1).
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: state=IDLE; all accumulators, counters and result registers cleared.
  - Outputs after reset: in_ready=0, out_valid=0, out_data=0, out_lane=0, out_last=0, busy=0.
  - Reset mid-operation discards the pixel; nothing partial is emitted.
- FSM: IDLE -> ACC -> RQ -> OUT -> IDLE.
- IDLE: in_ready=0.
  - start with cfg_in_ch>=1: latch cfg_in_ch, clear channel count, go to ACC.
  - start with cfg_in_ch==0: ignored.
- ACC: in_ready=1. On each in_valid&&in_ready, for every lane k: acc[k] = (count==0 ? acc_bias[k] : acc[k]) + in_data*w[k].
  - Products are sign-extended to ACC_W.
  - Accumulation wraps modulo 2^ACC_W.
  - The handshake with count==cfg_in_ch-1 moves to RQ.
- RQ: exactly one cycle; in_ready=0. Per lane:
  - p = acc*mul at full ACC_W+MUL_W precision.
  - If shift>0, add 1<<(shift-1) before an arithmetic right shift (round half up).
  - Add rq_bias.
  - Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - If relu6_en, clamp to [0, relu6_max].
  - Result registered in q[k].
  - mul/rq_bias/shift/relu6_* are sampled in the RQ cycle and must be stable from the last input handshake through RQ.
- OUT: out_valid=1, out_data=q[lane], out_lane=lane, out_last=(lane==PAR_OC-1).
  - Each handshake advances lane.
  - The handshake with out_last=1 returns to IDLE.
  - While out_ready=0, all out_* hold stable.
- Latency: out_valid rises 2 cycles after the last input handshake. Per-pixel cost = cfg_in_ch + 1 + PAR_OC cycles at full throughput.
- Simultaneous events: start outside IDLE is ignored. No overlap between pixels; a start in the cycle after the final output handshake is accepted.
- PAR_OC=1: out_lane tied 0; out_last=1 on every output.

Optional Feature:
- Macro PW_PAR_OC_ACC_SAT_EN.
- Defined: accumulation saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1] per beat and holds at the bound.
- Undefined: wrap-around as above.

Test Plan:
- Basic: PAR_OC=4, cfg_in_ch=3, in_data 1,2,3, lane k weight=k+1 every beat, acc_bias=0, mul=1, shift=0, rq_bias=0, relu6_en=1, relu6_max=127 -> outputs 6,12,18,24 on lanes 0..3; out_last only on lane 3; first out_valid 2 cycles after third input handshake.
- Rounding: cfg_in_ch=1, acc_bias=5 then -5, in_data=0, mul=1, shift=1, relu6_en=0 -> 3 then -2; repeat -5 with relu6_en=1 -> 0.
- Saturation/ReLU6: acc_bias=1000, in_data=0, mul=1, shift=0 -> 127 with relu6_en=0; with relu6_en=1, relu6_max=6 -> 6; acc_bias=-1000, relu6_en=0 -> -128.
- Backpressure: hold out_ready=0 for 5 cycles on lane 1 -> out_data, out_lane=1, out_valid stable; no lane skipped; exactly 4 outputs per pixel; start pulsed during OUT ignored.
- Reset mid-ACC: assert rst after 1 of 3 beats -> next cycle in_ready=0, busy=0; a fresh pixel with the basic stimulus gives 6,12,18,24 with no stale accumulation.
- Overflow: acc_bias=2^31-1, in_data=1, w=1, mul=1, shift=0, relu6_en=0 -> without PW_PAR_OC_ACC_SAT_EN output -128 (wrapped); with it, output 127.
